player_shot_unit: RTL
=====================

Name: player_shot_unit

Overview:
- Owns the player's single bullet and produces the per-alien `hit` pulses consumed by each alien instance.
- On `fire` it launches a bullet from the player's position and moves it upward on every frame tick.
- After each move it serially scans the alien grid for an overlap with a live alien. On a match it pulses that alien's `hit` line and retires the bullet.

Parameters:
N_ALIENS, 8, number of alien slots scanned (index 0..N_ALIENS-1)
ALIEN_W, 10, alien bounding-box width in pixels
ALIEN_H, 10, alien bounding-box height in pixels
BULLET_STEP, 4, pixels the bullet rises per tick
LAUNCH_Y, 460, bullet y coordinate at launch

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
tick  in  1  one-cycle frame-advance strobe
fire  in  1  launch request (level; sampled each cycle)
player_x  in  10  player bullet x origin
alien_x  in  10*N_ALIENS  packed alien x positions, slot i at [10*i+9:10*i]
alien_y  in  10*N_ALIENS  packed alien y positions, same packing
alien_alive  in  N_ALIENS  alive flag per alien
hit  out  N_ALIENS  one-hot, one-cycle hit pulse to alien i
bullet_active  out  1  bullet in flight
bullet_x  out  10  bullet x
bullet_y  out  10  bullet y

Behaviour:
- Reset (`rst` high at a clk edge): state IDLE, `hit`=0, `bullet_active`=0, `bullet_x`=0, `bullet_y`=0, scan index=0.
- All outputs are registered.
- States: IDLE, FLY, SCAN.
- IDLE:
  - `fire`=1 → `bullet_x`<=`player_x`, `bullet_y`<=LAUNCH_Y, `bullet_active`<=1, go FLY.
  - `tick` is ignored in IDLE, including when it coincides with `fire`.
- FLY, on `tick`=1:
  - If `bullet_y` < BULLET_STEP: `bullet_active`<=0, go IDLE (off-screen, no hit).
  - Else `bullet_y`<=`bullet_y`-BULLET_STEP, scan index<=0, go SCAN.
  - With `tick`=0: hold.
- SCAN: evaluates alien[idx] in one cycle, using the current `bullet_x`/`bullet_y` and the live input values of the alien ports.
  - Overlap condition: `alien_alive`[idx] && `bullet_x` >= ax && `bullet_x` < ax+ALIEN_W && `bullet_y` >= ay && `bullet_y` < ay+ALIEN_H.
  - Sums are computed 11 bits wide; no wrap.
  - On overlap: `hit`[idx]<=1 for exactly one cycle, `bullet_active`<=0, go IDLE. `bullet_x`/`bullet_y` hold their last values.
  - No overlap and idx==N_ALIENS-1: go FLY.
  - Otherwise idx<=idx+1.
- `hit` returns to 0 on the cycle after any pulse; at most one bit is set, at most one pulse per bullet.
- Priority: the lowest-index overlapping live alien wins; higher indices are never pulsed for the same bullet.
- Latency: with the tick sampled at edge E, alien i is evaluated at edge E+1+i and `hit`[i] is visible from edge E+1+i for one cycle.
- Full scan costs N_ALIENS cycles. Ticks arriving during SCAN are dropped; ticks are guaranteed ≥ N_ALIENS+1 cycles apart.
- `fire` while `bullet_active`=1 (FLY or SCAN) is ignored; there is no queueing.
- `fire` on the same cycle a hit or off-screen retire occurs is ignored. Relaunch is possible from the next cycle (IDLE).
- `alien_alive` deasserting mid-scan for a not-yet-scanned slot: that slot is not hit.
- Reset mid-flight or mid-scan: next cycle equals the reset state. Any pending `hit` is cancelled.
- Scan index width is $clog2(N_ALIENS), minimum 1.

Test Plan:
- Reset, then 10 idle cycles with `fire`=0 and `tick` pulses → `hit`=0, `bullet_active`=0, `bullet_x`=`bullet_y`=0 throughout.
- `player_x`=25, `fire` for 1 cycle → next cycle `bullet_active`=1, `bullet_x`=25, `bullet_y`=460.
- Alien 3 at (20,448) alive, others dead, bullet from x=25, one `tick` → `bullet_y`=456; `hit`=8'b0000_1000 for exactly 1 cycle, 4 cycles after the tick edge; `bullet_active`=0 the same cycle.
- Same setup with `alien_alive`[3]=0 → no hit; bullet continues. With all aliens dead, 115 ticks reach `bullet_y`=0 and tick 116 drops `bullet_active`. `fire` during flight (x=300) leaves `bullet_x`=25.
- Aliens 2 and 5 both at (20,448) alive, bullet x=25, one tick → only `hit`[2] pulses; `hit`[5] stays 0; `bullet_active`=0.
- Assert `rst` one cycle into SCAN with an overlapping alien at idx 6 → no `hit` pulse ever; next cycle all outputs 0. `fire` the following cycle relaunches normally.

Source files
------------

// File: rtl/player_shot_unit.sv
// Player bullet: launches on fire, rises on each frame tick, then serially
// scans the alien grid and pulses the first overlapping live alien's hit line.
module player_shot_unit #(
   parameter int N_ALIENS    = 8,
   parameter int ALIEN_W     = 10,
   parameter int ALIEN_H     = 10,
   parameter int BULLET_STEP = 4,
   parameter int LAUNCH_Y    = 460
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  tick,
   input  logic                  fire,
   input  logic [9:0]            player_x,
   input  logic [10*N_ALIENS-1:0] alien_x,
   input  logic [10*N_ALIENS-1:0] alien_y,
   input  logic [N_ALIENS-1:0]   alien_alive,
   output logic [N_ALIENS-1:0]   hit,
   output logic                  bullet_active,
   output logic [9:0]            bullet_x,
   output logic [9:0]            bullet_y
);

   localparam int IDX_W = (N_ALIENS > 1) ? $clog2(N_ALIENS) : 1;

   typedef enum logic [1:0] {IDLE, FLY, SCAN} state_t;

   state_t               state, state_nxt;
   logic [IDX_W-1:0]     idx, idx_nxt;
   logic [N_ALIENS-1:0]  hit_nxt;
   logic                 active_nxt;
   logic [9:0]           x_nxt, y_nxt;

   logic [9:0]           sel_x, sel_y;
   logic                 sel_alive;
   logic [N_ALIENS-1:0]  sel_onehot;
   logic                 overlap;

   // Pick out the alien currently addressed by the scan index.
   always_comb begin
      sel_x      = '0;
      sel_y      = '0;
      sel_alive  = 1'b0;
      sel_onehot = '0;
      for (int i = 0; i < N_ALIENS; i++) begin
         if (idx == IDX_W'(i)) begin
            sel_x         = alien_x[10*i +: 10];
            sel_y         = alien_y[10*i +: 10];
            sel_alive     = alien_alive[i];
            sel_onehot[i] = 1'b1;
         end
      end
   end

   // Box edges are widened to 11 bits so aliens near 1023 do not wrap.
   always_comb begin
      overlap = sel_alive
             && ({1'b0, bullet_x} >= {1'b0, sel_x})
             && ({1'b0, bullet_x} <  ({1'b0, sel_x} + 11'(ALIEN_W)))
             && ({1'b0, bullet_y} >= {1'b0, sel_y})
             && ({1'b0, bullet_y} <  ({1'b0, sel_y} + 11'(ALIEN_H)));
   end

   always_comb begin
      state_nxt  = state;
      idx_nxt    = idx;
      hit_nxt    = '0;
      active_nxt = bullet_active;
      x_nxt      = bullet_x;
      y_nxt      = bullet_y;
      case (state)
         IDLE: begin
            if (fire) begin
               x_nxt      = player_x;
               y_nxt      = 10'(LAUNCH_Y);
               active_nxt = 1'b1;
               state_nxt  = FLY;
            end
         end
         FLY: begin
            if (tick) begin
               if (bullet_y < 10'(BULLET_STEP)) begin
                  active_nxt = 1'b0;
                  state_nxt  = IDLE;
               end else begin
                  y_nxt     = bullet_y - 10'(BULLET_STEP);
                  idx_nxt   = '0;
                  state_nxt = SCAN;
               end
            end
         end
         SCAN: begin
            if (overlap) begin
               hit_nxt    = sel_onehot;
               active_nxt = 1'b0;
               state_nxt  = IDLE;
            end else if (idx == IDX_W'(N_ALIENS - 1)) begin
               state_nxt = FLY;
            end else begin
               idx_nxt = idx + IDX_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         idx           <= '0;
         hit           <= '0;
         bullet_active <= 1'b0;
         bullet_x      <= '0;
         bullet_y      <= '0;
      end else begin
         state         <= state_nxt;
         idx           <= idx_nxt;
         hit           <= hit_nxt;
         bullet_active <= active_nxt;
         bullet_x      <= x_nxt;
         bullet_y      <= y_nxt;
      end
   end

endmodule
